// File: rtl/aes_key_pkg.sv
// Shared constants for the inverse AES-128 key schedule: round count, final Rcon,
// forward S-box table and the backward Rcon step.
package aes_key_pkg;

  localparam int         NUM_ROUNDS = 10;
  localparam logic [7:0] RCON_LAST  = 8'h36;

  typedef enum logic {
    IDLE,
    OUT
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Undo one forward Rcon doubling; 0x1b is where the forward walk wrapped from 0x80.
  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    return (r == 8'h1b) ? 8'h80 : {1'b0, r[7:1]};
  endfunction

endpackage

// File: rtl/aes_sbox_dyn.sv
// Forward AES S-box with a dynamic output mask (result = S(value) ^ mask).
module aes_sbox_dyn
  import aes_key_pkg::*;
(
  input  logic [7:0] value,
  input  logic [7:0] mask,
  output logic [7:0] result
);

  assign result = SBOX[value] ^ mask;

endmodule

// File: rtl/aes_inv_key_sched.sv
// On-the-fly inverse AES-128 key schedule: streams round keys 10..0 from the last round key.
// Optional expected-key comparator enabled by macro AES_INV_KEY_CHECK_EN.
module aes_inv_key_sched
  import aes_key_pkg::*;
(
`ifdef AES_INV_KEY_CHECK_EN
  input  logic [0:127] exp_key,
  output logic         key_match,
`endif
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:127] last_key,
  input  logic [0:7]   sbox_mask,
  output logic [0:127] key_out,
  output logic [0:3]   key_no,
  output logic         key_valid,
  input  logic         key_ready,
  output logic         busy,
  output logic         done
);

  state_t       state_reg, state_next;
  logic [0:127] key_reg, key_next;
  logic [0:3]   no_reg, no_next;
  logic         valid_reg, valid_next;
  logic         busy_reg, busy_next;
  logic         done_reg, done_next;
  logic [7:0]   rcon_reg, rcon_next;
  logic [7:0]   mask_reg, mask_next;
`ifdef AES_INV_KEY_CHECK_EN
  logic         match_reg, match_next;
`endif

  logic [0:31]  w0, w1, w2, w3;
  logic [0:31]  p0, p1, p2, p3;
  logic [0:31]  rot, sub;
  logic [0:127] prev_key;

  assign w0 = key_reg[0:31];
  assign w1 = key_reg[32:63];
  assign w2 = key_reg[64:95];
  assign w3 = key_reg[96:127];

  // Forward schedule is w'[i] = w'[i-1] ^ w[i]; XORing neighbours recovers the previous words.
  assign p3  = w3 ^ w2;
  assign p2  = w2 ^ w1;
  assign p1  = w1 ^ w0;
  assign rot = {p3[8:31], p3[0:7]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
      aes_sbox_dyn u_sbox (
        .value  (rot[gi*8 +: 8]),
        .mask   (mask_reg),
        .result (sub[gi*8 +: 8])
      );
    end
  endgenerate

  assign p0       = w0 ^ sub ^ {rcon_reg, 24'h0};
  assign prev_key = {p0, p1, p2, p3};

  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    no_next    = no_reg;
    valid_next = valid_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    rcon_next  = rcon_reg;
    mask_next  = mask_reg;
`ifdef AES_INV_KEY_CHECK_EN
    match_next = match_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          key_next   = last_key;
          mask_next  = sbox_mask;
          no_next    = '0;
          rcon_next  = RCON_LAST;
          valid_next = 1'b1;
          busy_next  = 1'b1;
          state_next = OUT;
`ifdef AES_INV_KEY_CHECK_EN
          match_next = 1'b0;
`endif
        end
      end
      OUT: begin
        if (valid_reg && key_ready) begin
          if (no_reg == 4'(NUM_ROUNDS)) begin
            valid_next = 1'b0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
`ifdef AES_INV_KEY_CHECK_EN
            match_next = (key_reg == exp_key);
`endif
          end else begin
            key_next  = prev_key;
            no_next   = no_reg + 4'd1;
            rcon_next = inv_xtime(rcon_reg);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      key_reg   <= '0;
      no_reg    <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      rcon_reg  <= RCON_LAST;
      mask_reg  <= '0;
`ifdef AES_INV_KEY_CHECK_EN
      match_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      key_reg   <= key_next;
      no_reg    <= no_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      rcon_reg  <= rcon_next;
      mask_reg  <= mask_next;
`ifdef AES_INV_KEY_CHECK_EN
      match_reg <= match_next;
`endif
    end
  end

  assign key_out   = key_reg;
  assign key_no    = no_reg;
  assign key_valid = valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
`ifdef AES_INV_KEY_CHECK_EN
  assign key_match = match_reg;
`endif

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Scoreboard bench for aes_inv_key_sched: FIPS-197 vectors, backpressure, masked S-box,
// async reset and ignored starts. Key-match checks compile in with AES_INV_KEY_CHECK_EN.
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] last_key;
  logic [7:0]   sbox_mask;
  logic [127:0] key_out;
  logic [3:0]   key_no;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;
`ifdef AES_INV_KEY_CHECK_EN
  logic [127:0] exp_key;
  logic         key_match;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  aes_inv_key_sched dut (
`ifdef AES_INV_KEY_CHECK_EN
    .exp_key   (exp_key),
    .key_match (key_match),
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .last_key  (last_key),
    .sbox_mask (sbox_mask),
    .key_out   (key_out),
    .key_no    (key_no),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done)
  );

  // FIPS-197 Appendix A.1 round keys for cipher key 2b7e1516...
  localparam logic [127:0] FIPS [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  localparam logic [7:0] TB_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // mode 0: exact key+index, 1: index only, 2: index exact and key must differ
  typedef struct {
    logic [127:0] key;
    logic [3:0]   no;
    logic [1:0]   mode;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] fwd [11];

  // Forward (encryptor-side) expansion with masked S-box, result in fwd[0..10].
  task automatic expand(input logic [127:0] k, input logic [7:0] m);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {TB_SBOX[t[31:24]] ^ m, TB_SBOX[t[23:16]] ^ m, TB_SBOX[t[15:8]] ^ m, TB_SBOX[t[7:0]] ^ m};
        t[31:24] = t[31:24] ^ rc;
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) fwd[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_fips();
    for (int i = 0; i <= 10; i++) sb.push_back('{FIPS[10-i], 4'(i), 2'd0});
  endtask

  task automatic push_fwd();
    for (int i = 0; i <= 10; i++) sb.push_back('{fwd[10-i], 4'(i), 2'd0});
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic start_seq(input logic [127:0] k, input logic [7:0] m);
    start = 1'b1;
    last_key = k;
    sbox_mask = m;
    @(posedge clk); #1;
    start = 1'b0;
    sbox_mask = ~m;
    check("first_key_latency", {key_valid, busy, key_no}, {1'b1, 1'b1, 4'd0});
`ifdef AES_INV_KEY_CHECK_EN
    check("key_match_cleared", key_match, 0);
`endif
  endtask

  task automatic wait_key(input int n);
    for (int c = 0; c < 200; c++) begin
      if (key_valid && key_no == 4'(n)) return;
      @(posedge clk); #1;
    end
    check("wait_key_timeout", 0, 1);
  endtask

  task automatic wait_done();
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (done) begin
        check("sb_drained", sb.size(), 0);
        return;
      end
    end
    check("wait_done_timeout", 0, 1);
  endtask

  // Monitor: pops on every handshake, also checks hold-under-stall and post-handshake timing.
  logic         stall_prev, hs_mid_prev, hs_last_prev;
  logic [127:0] key_prev;
  logic [3:0]   no_prev;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_prev   = 1'b0;
      hs_mid_prev  = 1'b0;
      hs_last_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_hold_valid", key_valid, 1);
        check("stall_hold_key", key_out, key_prev);
        check("stall_hold_no", key_no, no_prev);
      end
      if (hs_mid_prev) check("next_key_1cycle", {key_valid, key_no}, {1'b1, no_prev + 4'd1});
      if (hs_last_prev) check("done_after_last", {done, busy, key_valid}, {1'b1, 1'b0, 1'b0});
      if (key_valid && key_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_key", {124'h0, key_no}, 128'hffff);
        end else begin
          e = sb.pop_front();
          check("key_no", key_no, e.no);
          if (e.mode == 2'd0) check("key_value", key_out, e.key);
          if (e.mode == 2'd2) begin
            tests++;
            if (key_out === e.key) begin
              fails++;
              $display("FAIL key_differs: got %h want any value except %h", key_out, e.key);
            end
          end
        end
      end
      stall_prev   = key_valid && !key_ready;
      hs_mid_prev  = key_valid && key_ready && (key_no != 4'd10);
      hs_last_prev = key_valid && key_ready && (key_no == 4'd10);
      key_prev     = key_out;
      no_prev      = key_no;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    key_ready = 1'b1;
    last_key = '0;
    sbox_mask = '0;
`ifdef AES_INV_KEY_CHECK_EN
    exp_key = FIPS[0];
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_key", key_out, 0);
    check("reset_ctrl", {key_no, key_valid, busy, done}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // plain FIPS-197 sequence, ready always high
    push_fips();
    start_seq(FIPS[10], 8'h00);
    wait_done();
`ifdef AES_INV_KEY_CHECK_EN
    check("key_match_hit", key_match, 1);
`endif

    // backpressure at key_no 4
    push_fips();
    start_seq(FIPS[10], 8'h00);
    wait_key(4);
    key_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    key_ready = 1'b1;
    wait_done();

    // masked S-box: encryptor expansion with 0x5a, inverse must recover the cipher key
    expand(FIPS[0], 8'h5a);
    push_fwd();
    start_seq(fwd[10], 8'h5a);
    wait_done();
    for (int i = 0; i < 10; i++) sb.push_back('{128'h0, 4'(i), 2'd1});
    sb.push_back('{FIPS[0], 4'd10, 2'd2});
    start_seq(fwd[10], 8'h00);
    wait_done();

    // asynchronous reset in the middle of the sequence
    push_fips();
    start_seq(FIPS[10], 8'h00);
    wait_key(6);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {key_valid, busy, key_no}, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_fwd();
    start_seq(fwd[10], 8'h5a);
    wait_done();

    // start during OUT is ignored
    push_fips();
    start_seq(FIPS[10], 8'h00);
    wait_key(3);
    start = 1'b1;
    last_key = fwd[10];
    sbox_mask = 8'h5a;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
`ifdef AES_INV_KEY_CHECK_EN
    check("key_match_hit2", key_match, 1);
    exp_key = FIPS[0] ^ {1'b1, 127'h0};
`endif

    // start coinciding with the final handshake is ignored
    push_fips();
    start_seq(FIPS[10], 8'h00);
    wait_key(10);
    start = 1'b1;
    last_key = fwd[10];
    @(posedge clk); #1;
    start = 1'b0;
    check("done_at_final", done, 1);
    @(posedge clk); #1;
    check("start_at_final_ignored", {busy, key_valid}, 0);
`ifdef AES_INV_KEY_CHECK_EN
    check("key_match_miss", key_match, 0);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
- On-the-fly inverse AES-128 key schedule for the decryption side.
- Takes the last round key (round 10) and streams round keys 10 down to 0, one per accepted handshake.
- Key index uses the decryptor's convention: key_no 0 = round-10 key, key_no 10 = original cipher key.
- Replaces the ten-entry round-key register bank between encryptor and decryptor. Uses the same dynamic S-box mask as the encryptor.

Parameters:
- NUM_ROUNDS, 10, number of AES rounds. Only 10 (AES-128) is supported.
- RCON_LAST, 8'h36, Rcon value of the final forward round. It is the starting value for the backward Rcon walk.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that loads last_key and sbox_mask. Ignored while busy=1.
- last_key  input  [0:127]  round-10 key. Byte 0 = bits 0:7.
- sbox_mask  input  [0:7]  dynamic S-box mask; every S-box output is XORed with it.
- key_out  output  [0:127]  current round key.
- key_no  output  [0:3]  index of key_out, 0..10.
- key_valid  output  1  key_out/key_no valid.
- key_ready  input  1  consumer accepts the key when key_valid&&key_ready.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse after key_no 10 is accepted.

Behaviour:
- Reset, asynchronous, applies any cycle including mid-sequence: state=IDLE; key_out=0, key_no=0, key_valid=0, busy=0, done=0; rcon=RCON_LAST; mask register=0.
- States and transitions:
  - IDLE: on start, capture last_key into key_out and sbox_mask into the mask register; key_no=0, rcon=RCON_LAST, key_valid=1, busy=1 -> OUT. First key is visible 1 cycle after start.
  - OUT, on key_valid&&key_ready:
    - if key_no<10: key_out<=prev(key_out, rcon); key_no<=key_no+1; rcon<=inv_xtime(rcon); key_valid stays 1. New key is visible the next cycle, so throughput is 1 key/cycle with ready held high.
    - if key_no==10: key_valid<=0, busy<=0, done<=1 -> IDLE.
  - Backpressure: without a handshake, key_out and key_no hold stable while key_valid=1.
- prev() per FIPS-197, words w0..w3 of the current key:
  - p3=w3^w2, p2=w2^w1, p1=w1^w0.
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {rcon,24'h0}.
  - RotWord = left rotate by one byte.
  - SubWord = AES S-box per byte, XOR mask.
- inv_xtime(r): 8'h80 if r==8'h1b, else r>>1. Sequence 36,1b,80,40,20,10,08,04,02,01.
- Boundary cases:
  - start in OUT: ignored, no reload.
  - start in the same cycle as the final handshake: ignored. start is accepted only in IDLE.
  - mask change mid-sequence: no effect; the value latched at start is used.
  - key_no never exceeds 10.

Optional Feature:
- Macro AES_INV_KEY_CHECK_EN.
- When defined, adds input exp_key [0:127] and output key_match (1 bit).
- key_match is cleared to 0 on reset and on accepted start.
- key_match is set to 1 in the done cycle if the key_no 10 value equals exp_key; otherwise it stays 0. It holds until the next start.
- When undefined, neither port exists and there is no comparator logic.

Decomposition:
- Package aes_key_pkg holds NUM_ROUNDS, RCON_LAST, the 256-entry S-box constant and the inv_xtime function.
- One combinational sub-module, aes_sbox_dyn (8-bit in, mask in, 8-bit out), instanced 4 times for SubWord.

Test Plan:
- Sequence check: mask 0, last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, ready=1. Require key_no0=d014f9a8..., key_no1=ac7766f319fadc2128d12941575c006e, key_no10=2b7e151628aed2a6abf7158809cf4f3c, and done 1 cycle after the key_no 10 handshake.
- Backpressure: ready low for 3 cycles at key_no 4 -> key_out/key_no stable. After release, key_no5 appears next cycle and the remaining keys match the ready=1 run.
- Dynamic mask: run the encryptor's forward expansion with mask 8'h5a, feed its round-10 key -> key_no 10 equals the original key. With the same key and mask 0 instead -> mismatch.
- Reset at key_no 6: rst_n low -> key_valid, busy, key_no immediately 0. A new start restarts at key_no 0 with the new key.
- start pulsed at key_no 3 -> ignored, sequence continues unchanged. With AES_INV_KEY_CHECK_EN and exp_key=2b7e1516... -> key_match=1 at done; exp_key with bit 0 flipped -> 0.
